// File: rtl/ov7670_capture_pkg.sv
// Shared definitions for the OV7670 capture path: default geometry, FSM
// encoding and the RGB565 -> RGB332 packing used by writer, reader and models.
package ov7670_capture_pkg;

   localparam int H_PIXELS_DEF = 176;
   localparam int V_LINES_DEF  = 120;
   localparam int ADDR_W_DEF   = 15;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      VBLANK  = 2'd1,
      ACTIVE  = 2'd2
   } cap_state_e;

   // hi carries R[4:0]G[5:3], lo carries G[2:0]B[4:0]; keep the top bits of each colour.
   function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
      return {hi[7:5], hi[2:0], lo[4:3]};
   endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Frame-buffer write port: the capture block drives it, the dual-port RAM consumes it.
interface ov7670_capture_if
   import ov7670_capture_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_data;
   logic              w_en;

   modport master (output w_addr, output w_data, output w_en);
   modport slave  (input  w_addr, input  w_data, input  w_en);
endinterface

// File: rtl/ov7670_capture.sv
// Camera-clock writer: frames RGB565 byte pairs with VSYNC/HREF and writes one
// RGB332 byte per pixel in raster order into a H_PIXELS x V_LINES window.
module ov7670_capture
   import ov7670_capture_pkg::*;
#(
   parameter int H_PIXELS = H_PIXELS_DEF,
   parameter int V_LINES  = V_LINES_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             capture_en,
   input  logic             vsync,
   input  logic             href,
   input  logic [7:0]       d,
   ov7670_capture_if.master wr,
   output logic             frame_done,
   output logic             busy
);

   localparam int COL_W  = $clog2(H_PIXELS + 1);
   localparam int LINE_W = $clog2(V_LINES + 1);
   localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_PIXELS);
   localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_LINES);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

   cap_state_e        state_q, state_d;
   logic              vs_q, hr_q, hr_q2;
   logic [7:0]        d_q;
   logic [COL_W-1:0]  col_q, col_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [ADDR_W-1:0] line_base_q, line_base_d;
   logic              phase_q, phase_d;
   logic [7:0]        hi_q, hi_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [7:0]        w_data_q, w_data_d;
   logic              w_en_q, w_en_d;
   logic              frame_done_q, frame_done_d;
   logic              busy_q, busy_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WAIT_VS;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_VS: if (vs_q) state_d = VBLANK; else state_d = WAIT_VS;
         VBLANK: begin
            if (!vs_q) state_d = capture_en ? ACTIVE : WAIT_VS;
            else       state_d = VBLANK;
         end
         ACTIVE:  if (vs_q) state_d = VBLANK; else state_d = ACTIVE;
         default: state_d = WAIT_VS;
      endcase
   end

   // Pixel datapath: byte pairing, window bounds and line accounting.
   always_comb begin
      col_d        = col_q;
      line_d       = line_q;
      line_base_d  = line_base_q;
      phase_d      = phase_q;
      hi_d         = hi_q;
      w_addr_d     = w_addr_q;
      w_data_d     = w_data_q;
      w_en_d       = 1'b0;
      frame_done_d = 1'b0;
      busy_d       = (state_d == ACTIVE);
      if (state_q == VBLANK && state_d == ACTIVE) begin
         col_d       = {COL_W{1'b0}};
         line_d      = {LINE_W{1'b0}};
         line_base_d = {ADDR_W{1'b0}};
         phase_d     = 1'b0;
      end else if (state_q == ACTIVE && vs_q) begin
         frame_done_d = 1'b1;
      end else if (state_q == ACTIVE && hr_q) begin
         if (!phase_q) begin
            hi_d    = d_q;
            phase_d = 1'b1;
         end else begin
            phase_d = 1'b0;
            if (col_q < COL_MAX && line_q < LINE_MAX) begin
               w_en_d   = 1'b1;
               w_addr_d = line_base_q + ADDR_W'(col_q);
               w_data_d = rgb565_to_rgb332(hi_q, d_q);
            end else begin
               w_en_d = 1'b0;
            end
            if (col_q < COL_MAX) col_d = col_q + COL_W'(1);
            else                 col_d = col_q;
         end
      end else if (state_q == ACTIVE && hr_q2) begin
         // Falling HREF; a line with no complete pixel does not advance the row.
         if (col_q != {COL_W{1'b0}}) begin
            if (line_q < LINE_MAX)  line_d = line_q + LINE_W'(1);
            else                    line_d = line_q;
            if (line_q < LINE_LAST) line_base_d = line_base_q + LINE_STEP;
            else                    line_base_d = line_base_q;
         end else begin
            line_d = line_q;
         end
         col_d   = {COL_W{1'b0}};
         phase_d = 1'b0;
      end else begin
         hi_d = hi_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vs_q         <= 1'b0;
         hr_q         <= 1'b0;
         hr_q2        <= 1'b0;
         d_q          <= 8'd0;
         col_q        <= {COL_W{1'b0}};
         line_q       <= {LINE_W{1'b0}};
         line_base_q  <= {ADDR_W{1'b0}};
         phase_q      <= 1'b0;
         hi_q         <= 8'd0;
         w_addr_q     <= {ADDR_W{1'b0}};
         w_data_q     <= 8'd0;
         w_en_q       <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         vs_q         <= vsync;
         hr_q         <= href;
         hr_q2        <= hr_q;
         d_q          <= d;
         col_q        <= col_d;
         line_q       <= line_d;
         line_base_q  <= line_base_d;
         phase_q      <= phase_d;
         hi_q         <= hi_d;
         w_addr_q     <= w_addr_d;
         w_data_q     <= w_data_d;
         w_en_q       <= w_en_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign wr.w_addr  = w_addr_q;
   assign wr.w_data  = w_data_q;
   assign wr.w_en    = w_en_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed-plus-random bench for ov7670_capture with a frame-level reference model.
module tb_ov7670_capture;
   import ov7670_capture_pkg::*;

   localparam int H = 176;
   localparam int V = 120;

   logic       clk = 1'b0;
   logic       reset, capture_en, vsync, href;
   logic [7:0] d;
   logic       frame_done, busy;

   ov7670_capture_if wr ();

   ov7670_capture dut (
      .clk        (clk),
      .reset      (reset),
      .capture_en (capture_en),
      .vsync      (vsync),
      .href       (href),
      .d          (d),
      .wr         (wr),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [22:0] got_q[$];
   logic [22:0] exp_q[$];
   int          widths[$];
   int          fd_count = 0;
   int          fd_cyc = 0;
   int          last_wen_cyc = -100;
   int          min_gap = 1000;
   int          last_addr = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr.w_en === 1'b1) begin
         got_q.push_back({wr.w_addr, wr.w_data});
         if (cyc - last_wen_cyc < min_gap) min_gap <= cyc - last_wen_cyc;
         last_wen_cyc <= cyc;
      end
      if (frame_done === 1'b1) begin
         fd_count <= fd_count + 1;
         fd_cyc   <= cyc;
      end
   end

   // Reference packing written arithmetically: R3 = hi/32, G3 = hi%8, B2 = (lo/8)%4.
   function automatic logic [7:0] ref_pack(input int hi, input int lo);
      return 8'((hi / 32) * 32 + (hi % 8) * 4 + (lo / 8) % 4);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      href  = 1'b0;
      reset = 1'b0;
      d     = 8'($urandom_range(0, 255));
   endtask

   task automatic run_frame(input string name, input bit cap, input bit raise_mid,
                            input int gap, input int tail, input int rst_line,
                            input int rst_byte, input bit fixed, input bit chk_fd);
      int         lineno;
      bit         aborted;
      int         fd0;
      int         nb;
      int         p;
      int         fails;
      int         n;
      logic [7:0] hi;
      logic [7:0] byte_v;
      lineno  = 0;
      aborted = 1'b0;
      fd0     = fd_count;
      hi      = 8'd0;
      repeat (3) begin
         @(negedge clk);
         vsync = 1'b1;
         href  = 1'b0;
         reset = 1'b0;
      end
      @(negedge clk);
      vsync      = 1'b0;
      capture_en = cap;
      repeat (3) @(negedge clk);
      for (int li = 0; li < widths.size(); li++) begin
         nb = widths[li];
         for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            if (fixed) byte_v = (b % 2 == 0) ? 8'hE5 : 8'h18;
            else       byte_v = 8'($urandom_range(0, 255));
            href  = 1'b1;
            d     = byte_v;
            reset = (li == rst_line && b == rst_byte);
            if (reset) aborted = 1'b1;
            if (b % 2 == 0) begin
               hi = byte_v;
            end else begin
               p = b / 2;
               // The write for the pair completed just before reset is still in flight.
               if (cap && !aborted && !(li == rst_line && 2 * p + 2 >= rst_byte) &&
                   p < H && lineno < V)
                  exp_q.push_back({15'(lineno * H + p), ref_pack(hi, byte_v)});
            end
         end
         if (nb >= 2 && lineno < V) lineno++;
         if (li == widths.size() - 1) begin
            repeat (tail) idle();
         end else begin
            repeat (gap) idle();
         end
         if (raise_mid && li == 1) capture_en = 1'b1;
         if (li == 0) check({name, " busy mid-frame"}, 32'(busy), 32'(cap && !aborted));
      end
      @(negedge clk);
      href  = 1'b0;
      reset = 1'b0;
      vsync = 1'b1;
      repeat (4) @(negedge clk);
      check({name, " frame_done count"}, 32'(fd_count - fd0), 32'(cap && !aborted));
      check({name, " busy after frame"}, 32'(busy), 32'd0);
      check({name, " write count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      fails = 0;
      for (int i = 0; i < n && fails < 4; i++) begin
         if (got_q[i] !== exp_q[i]) fails++;
         check({name, " write addr/data"}, 32'(got_q[i]), 32'(exp_q[i]));
      end
      if (chk_fd) check({name, " frame_done latency"}, 32'(fd_cyc - last_wen_cyc), 32'(tail + 1));
      last_addr = (got_q.size() > 0) ? int'(got_q[got_q.size() - 1][22:8]) : -1;
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      reset      = 1'b1;
      capture_en = 1'b0;
      vsync      = 1'b0;
      href       = 1'b0;
      d          = 8'd0;
      repeat (3) @(negedge clk);
      check("reset w_addr", 32'(wr.w_addr), 32'd0);
      check("reset w_data", 32'(wr.w_data), 32'd0);
      check("reset w_en", 32'(wr.w_en), 32'd0);
      check("reset frame_done", 32'(frame_done), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      reset = 1'b0;

      widths.delete();
      repeat (V) widths.push_back(2 * H);
      run_frame("nominal", 1'b1, 1'b0, 1, 0, -1, -1, 1'b1, 1'b1);
      check("nominal last addr", 32'(last_addr), 32'd21119);

      widths = '{7, 7, 1, 12, 3, 20};
      run_frame("odd bytes", 1'b1, 1'b0, 2, 3, -1, -1, 1'b0, 1'b0);

      widths.delete();
      repeat (5) widths.push_back($urandom_range(2, 30));
      run_frame("capture off", 1'b0, 1'b0, 2, 2, -1, -1, 1'b0, 1'b0);
      run_frame("enable mid-frame", 1'b0, 1'b1, 2, 2, -1, -1, 1'b0, 1'b0);
      run_frame("re-enabled", 1'b1, 1'b0, 1, 1, -1, -1, 1'b0, 1'b0);

      widths.delete();
      repeat (6) widths.push_back(100);
      run_frame("reset mid-line", 1'b1, 1'b0, 2, 2, 3, 80, 1'b0, 1'b0);
      widths.delete();
      repeat (4) widths.push_back($urandom_range(2, 40));
      run_frame("after reset", 1'b1, 1'b0, 1, 0, -1, -1, 1'b0, 1'b0);

      widths.delete();
      for (int li = 0; li < 130; li++) begin
         if (li == 0 || li == 60 || li == V - 1 || li == 125) widths.push_back(400);
         else widths.push_back($urandom_range(2, 20));
      end
      run_frame("oversize", 1'b1, 1'b0, 1, 2, -1, -1, 1'b0, 1'b0);
      check("oversize last addr", 32'(last_addr), 32'd21119);

      for (int f = 0; f < 3; f++) begin
         widths.delete();
         repeat ($urandom_range(3, 10)) widths.push_back($urandom_range(1, 40));
         run_frame("random", 1'b1, 1'b0, $urandom_range(1, 4), $urandom_range(0, 3),
                   -1, -1, 1'b0, 1'b0);
      end

      check("w_en spacing >= 2", 32'(min_gap >= 2), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Camera-side writer for the frame buffer. Runs on the OV7670 pixel clock, frames incoming RGB565 byte pairs using VSYNC/HREF, and packs each pair into one RGB332 byte. It drives the write port of the dual-port frame-buffer RAM with a raster-order address, one write per pixel, bounded to a 176×120 window. The VGA side reads the same RAM independently.

## Interface
- `H_PIXELS`, 176: pixels stored per line.
- `V_LINES`, 120: lines stored per frame.
- `ADDR_W`, 15: write-address width; must satisfy 2^ADDR_W ≥ H_PIXELS*V_LINES.
- `clk`  in  1  camera PCLK; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `capture_en`  in  1  permits capture of the next frame; sampled only at frame start.
- `vsync`  in  1  camera VSYNC, active-high during vertical blank.
- `href`  in  1  camera HREF, high while line bytes are valid.
- `d`  in  8  camera data byte.
- `w_addr`  out  ADDR_W  RAM write address.
- `w_data`  out  8  RGB332 pixel.
- `w_en`  out  1  one-cycle write strobe.
- `frame_done`  out  1  one-cycle pulse at the end of each captured frame.
- `busy`  out  1  high while in ACTIVE.

## Operation
- Input stage: `vsync`, `href`, `d` registered once (`vs_q`, `hr_q`, `d_q`). All control logic uses the registered copies. `hr_q2` holds the previous `hr_q` for edge detection.
- States:
  - WAIT_VS (reset state): go to VBLANK when `vs_q`=1. Discards partial frames after reset.
  - VBLANK: on `vs_q`=0, go to ACTIVE if `capture_en`=1, else go to WAIT_VS. On entry to ACTIVE, clear `col`, `line`, `line_base`, and `phase`.
  - ACTIVE: on `vs_q`=1, pulse `frame_done` and go to VBLANK.
- Byte phase, in ACTIVE with `hr_q`=1:
  - `phase`=0: store `d_q` in `hi`; set `phase`=1.
  - `phase`=1: form pixel {`hi[7:5]`, `hi[2:0]`, `d_q[4:3]`}; set `phase`=0.
  - The pixel is written when `col`<H_PIXELS and `line`<V_LINES, at `w_addr` = `line_base`+`col`. Then `col`++ (saturates at H_PIXELS).
- Line end, `hr_q2`=1 and `hr_q`=0 in ACTIVE:
  - If `col`≠0: `line`++ (saturates at V_LINES) and `line_base` += H_PIXELS.
  - Always: `col`=0, `phase`=0. A dangling odd byte is discarded.
- No multiplier. `line_base` is an accumulator of ADDR_W bits and never exceeds H_PIXELS*(V_LINES−1).
- Lines wider than H_PIXELS are truncated; lines beyond V_LINES are dropped. Neither case wraps the address.
- Frame with fewer lines: the unwritten RAM locations keep their stale contents. `frame_done` still pulses.
- `capture_en` deasserted mid-frame has no effect until the next frame start.
- `reset` mid-frame: return to WAIT_VS and zero all outputs on the next edge. The in-flight write is suppressed.

## Timing
- Reset values: `w_addr`=0, `w_data`=0, `w_en`=0, `frame_done`=0, `busy`=0.
- All outputs are registered.
- Second byte of a pixel present on `d` at edge k → `w_en`=1 with valid `w_addr`/`w_data` after edge k+1, for exactly one cycle.
- `w_en` rate: at most one strobe per 2 cycles.
- `frame_done`: asserted after the edge following the edge at which `vsync`=1 is first sampled (two edges after the pin rises), for one cycle. It never coincides with `w_en` for the same frame's last pixel cycle, because the 2-edge pipeline drains first.
- `busy` is high from ACTIVE entry until the edge that issues `frame_done`.

## Structure
- Shared package: the state encoding (WAIT_VS, VBLANK, ACTIVE) and the RGB565→RGB332 bit-select function, so the VGA-side reader and test models reuse the packing.
- Default geometry constants (176, 120, 15) also live in the package.
- A single module is natural; no sub-module. The pixel packer is a package function, not an instance.

## Test plan
- Nominal frame: VS pulse, then 120 lines of 352 bytes with byte pair (0xE5, 0x18) → 21120 writes, addresses 0..21119 in order, `w_data`=0xE5… exact value {111,101,11}=0xF7, one `frame_done`.
- Reset mid-line at pixel 40 of line 3, then a full frame → no writes until after the next VS rise/fall; the following frame starts at `w_addr`=0.
- Oversize input: 200 pixels × 130 lines → last write at `w_addr`=21119; no writes with col≥176 or line≥120; no address wrap.
- Odd byte count: a line of 7 bytes → 3 writes; the next line starts at `line_base`=176·(n+1) with `phase`=0.
- `capture_en`=0 at the VS fall → zero writes that frame and no `frame_done`. `capture_en` raised mid-frame → no effect until the next frame.
- HREF back-to-back with gaps of 1 cycle and VS rising 1 cycle after the last byte → last pixel written, then `frame_done` one cycle after that `w_en`.
